n_bits_select_stream_demux: RTL and testbench



---
 rtl/n_bits_demux_pkg.sv | 28 ++
 rtl/n_bits_select_decoder.sv | 31 +++
 rtl/n_bits_select_stream_demux.sv | 116 +++++++++++
 tb/tb_n_bits_select_stream_demux.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/n_bits_demux_pkg.sv
// Shared types and helpers for the n-bit select stream demultiplexer.
package n_bits_demux_pkg;

    // Output stage occupancy.
    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } demux_state_e;

    // Widest select the decode helper handles; bounds SEL_BITS and CHANNELS.
    localparam int unsigned MaxSelBits  = 6;
    localparam int unsigned MaxChannels = 2 ** MaxSelBits;

    // One-hot decode of sel, restricted to the first 'channels' outputs.
    // Selects at or beyond 'channels' decode to all zeros.
    function automatic logic [MaxChannels-1:0] sel_onehot(
        input logic [MaxSelBits-1:0] sel,
        input int unsigned           channels
    );
        logic [MaxChannels-1:0] dec;
        dec = '0;
        if (32'(sel) < channels) begin
            dec[sel] = 1'b1;
        end
        return dec;
    endfunction

endpackage

// File: rtl/n_bits_select_decoder.sv
// Combinational SEL_BITS -> CHANNELS one-hot decoder with enable and an
// out-of-range flag (sel >= CHANNELS). The flag ignores the enable.
module n_bits_select_decoder
    import n_bits_demux_pkg::*;
#(
    parameter int unsigned SEL_BITS = 2,
    parameter int unsigned CHANNELS = 4
) (
    input  logic [SEL_BITS-1:0] sel_i,
    input  logic                en_i,
    output logic [CHANNELS-1:0] onehot_o,
    output logic                out_of_range_o
);

    logic [MaxSelBits-1:0]  sel_ext;
    logic [MaxChannels-1:0] dec_full;
    logic                   unused_dec_upper;

    assign sel_ext = MaxSelBits'(sel_i);

    // Decode the select and gate it with the enable.
    always_comb begin
        dec_full       = sel_onehot(sel_ext, CHANNELS);
        onehot_o       = en_i ? dec_full[CHANNELS-1:0] : '0;
        out_of_range_o = (32'(sel_ext) >= CHANNELS);
    end

    // Bits above CHANNELS are always zero by construction of the helper.
    assign unused_dec_upper = ^dec_full;

endmodule

// File: rtl/n_bits_select_stream_demux.sv
// Registered valid/ready stream demultiplexer: each input beat carries a
// select that routes it to one of CHANNELS outputs through a single output
// register. Beats with select >= CHANNELS are accepted and dropped.
// Optional build macro DEMUX_DROP_COUNT_EN adds a saturating dropped-beat
// counter on DROP_COUNT; without it DROP_COUNT is tied to zero.
module n_bits_select_stream_demux
    import n_bits_demux_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SEL_BITS      = 2,
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned DROP_CNT_BITS = 8
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [WIDTH-1:0]         IN_DATA,
    input  logic [SEL_BITS-1:0]      IN_SEL,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    output logic [WIDTH-1:0]         OUT_DATA,
    output logic [CHANNELS-1:0]      OUT_VALID,
    input  logic [CHANNELS-1:0]      OUT_READY,
    output logic [DROP_CNT_BITS-1:0] DROP_COUNT
);

    demux_state_e        state_q;
    logic [WIDTH-1:0]    data_q;
    logic [SEL_BITS-1:0] sel_q;

    logic                in_fire;
    logic                out_fire;
    logic                in_illegal;
    logic                held_illegal_unused;
    logic [CHANNELS-1:0] in_onehot_unused;

    // Output valids come straight from the held select.
    n_bits_select_decoder #(
        .SEL_BITS(SEL_BITS),
        .CHANNELS(CHANNELS)
    ) u_out_decoder (
        .sel_i         (sel_q),
        .en_i          (state_q == StFull),
        .onehot_o      (OUT_VALID),
        .out_of_range_o(held_illegal_unused)
    );

    // Legality check of the incoming select.
    n_bits_select_decoder #(
        .SEL_BITS(SEL_BITS),
        .CHANNELS(CHANNELS)
    ) u_in_decoder (
        .sel_i         (IN_SEL),
        .en_i          (1'b1),
        .onehot_o      (in_onehot_unused),
        .out_of_range_o(in_illegal)
    );

    // Handshake decode; only the selected channel's ready can reach IN_READY
    // because OUT_VALID is one-hot on the held select.
    always_comb begin
        out_fire = |(OUT_VALID & OUT_READY);
        IN_READY = RST_N && ((state_q == StEmpty) || out_fire);
        in_fire  = IN_VALID && IN_READY;
    end

    assign OUT_DATA = data_q;

    // Output stage: load on a legal accepted beat, empty when drained with
    // nothing legal to replace it, otherwise hold.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StEmpty;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_fire && !in_illegal) begin
                        state_q <= StFull;
                        data_q  <= IN_DATA;
                        sel_q   <= IN_SEL;
                    end
                end
                StFull: begin
                    if (out_fire) begin
                        if (in_fire && !in_illegal) begin
                            data_q <= IN_DATA;
                            sel_q  <= IN_SEL;
                        end else begin
                            state_q <= StEmpty;
                        end
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

`ifdef DEMUX_DROP_COUNT_EN
    logic [DROP_CNT_BITS-1:0] drop_q;

    // Count accepted beats with an out-of-range select, saturating.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            drop_q <= '0;
        end else if (in_fire && in_illegal && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign DROP_COUNT = drop_q;
`else
    assign DROP_COUNT = '0;
`endif

endmodule

// File: tb/tb_n_bits_select_stream_demux.sv
// Directed bench for n_bits_select_stream_demux: default 4-channel instance
// plus a 5-channel / 3-bit-select instance to exercise illegal selects.
module tb_n_bits_select_stream_demux;

    logic       clk;
    logic       rst_n;

    // Instance A: WIDTH 8, SEL_BITS 2, CHANNELS 4
    logic [7:0] a_in_data;
    logic [1:0] a_in_sel;
    logic       a_in_valid;
    logic       a_in_ready;
    logic [7:0] a_out_data;
    logic [3:0] a_out_valid;
    logic [3:0] a_out_ready;
    logic [7:0] a_drop_count;

    // Instance B: WIDTH 8, SEL_BITS 3, CHANNELS 5, DROP_CNT_BITS 2
    logic [7:0] b_in_data;
    logic [2:0] b_in_sel;
    logic       b_in_valid;
    logic       b_in_ready;
    logic [7:0] b_out_data;
    logic [4:0] b_out_valid;
    logic [4:0] b_out_ready;
    logic [1:0] b_drop_count;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_v;
    logic [1:0] exp_drop_3;

    n_bits_select_stream_demux #(
        .WIDTH        (8),
        .SEL_BITS     (2),
        .CHANNELS     (4),
        .DROP_CNT_BITS(8)
    ) dut_a (
        .CLK       (clk),
        .RST_N     (rst_n),
        .IN_DATA   (a_in_data),
        .IN_SEL    (a_in_sel),
        .IN_VALID  (a_in_valid),
        .IN_READY  (a_in_ready),
        .OUT_DATA  (a_out_data),
        .OUT_VALID (a_out_valid),
        .OUT_READY (a_out_ready),
        .DROP_COUNT(a_drop_count)
    );

    n_bits_select_stream_demux #(
        .WIDTH        (8),
        .SEL_BITS     (3),
        .CHANNELS     (5),
        .DROP_CNT_BITS(2)
    ) dut_b (
        .CLK       (clk),
        .RST_N     (rst_n),
        .IN_DATA   (b_in_data),
        .IN_SEL    (b_in_sel),
        .IN_VALID  (b_in_valid),
        .IN_READY  (b_in_ready),
        .OUT_DATA  (b_out_data),
        .OUT_VALID (b_out_valid),
        .OUT_READY (b_out_ready),
        .DROP_COUNT(b_drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef DEMUX_DROP_COUNT_EN
        exp_drop_3 = 2'd3;
`else
        exp_drop_3 = 2'd0;
`endif
        rst_n       = 1'b0;
        a_in_data   = '0;
        a_in_sel    = '0;
        a_in_valid  = 1'b0;
        a_out_ready = 4'hF;
        b_in_data   = '0;
        b_in_sel    = '0;
        b_in_valid  = 1'b0;
        b_out_ready = 5'h1F;

        // Reset: IN_READY forced low while held.
        tick();
        check("rst_in_ready_low", 32'(a_in_ready), 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        check("rel_out_valid", 32'(a_out_valid), 32'h0);
        check("rel_out_data", 32'(a_out_data), 32'h0);
        check("rel_drop_a", 32'(a_drop_count), 32'h0);
        check("rel_in_ready", 32'(a_in_ready), 32'h1);

        // Single beat 0xA5 to channel 2.
        a_in_valid = 1'b1;
        a_in_data  = 8'hA5;
        a_in_sel   = 2'd2;
        tick();
        a_in_valid = 1'b0;
        check("single_valid", 32'(a_out_valid), 32'h4);
        check("single_data", 32'(a_out_data), 32'hA5);
        tick();
        check("single_once", 32'(a_out_valid), 32'h0);

        // Back-to-back stream to channels 0..3.
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in_sel   = 2'(i);
            a_in_data  = 8'(8'h10 + i);
            #1;
            check("stream_in_ready", 32'(a_in_ready), 32'h1);
            tick();
            exp_v = 4'b0001 << i;
            check("stream_valid", 32'(a_out_valid), 32'(exp_v));
            check("stream_data", 32'(a_out_data), 32'(8'h10 + i));
        end
        a_in_valid = 1'b0;
        tick();
        check("stream_drained", 32'(a_out_valid), 32'h0);

        // Stall on channel 3; channel 0 ready must not release it.
        a_out_ready = 4'b0001;
        a_in_valid  = 1'b1;
        a_in_sel    = 2'd3;
        a_in_data   = 8'h3C;
        tick();
        a_in_sel  = 2'd1;
        a_in_data = 8'h77;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_in_ready", 32'(a_in_ready), 32'h0);
            check("stall_valid", 32'(a_out_valid), 32'h8);
            check("stall_data", 32'(a_out_data), 32'h3C);
            tick();
        end
        a_out_ready = 4'hF;
        #1;
        check("drain_in_ready", 32'(a_in_ready), 32'h1);
        tick();
        a_in_valid = 1'b0;
        check("drain_next_valid", 32'(a_out_valid), 32'h2);
        check("drain_next_data", 32'(a_out_data), 32'h77);
        tick();
        check("drain_empty", 32'(a_out_valid), 32'h0);

        // Instance B: illegal selects 5,6,7 are consumed and dropped.
        for (int i = 5; i < 8; i++) begin
            b_in_valid = 1'b1;
            b_in_sel   = 3'(i);
            b_in_data  = 8'(8'hE0 + i);
            #1;
            check("drop_in_ready", 32'(b_in_ready), 32'h1);
            tick();
            check("drop_no_valid", 32'(b_out_valid), 32'h0);
        end
        b_in_sel  = 3'd4;
        b_in_data = 8'h5A;
        tick();
        b_in_valid = 1'b0;
        check("legal_after_drop_valid", 32'(b_out_valid), 32'h10);
        check("legal_after_drop_data", 32'(b_out_data), 32'h5A);
        check("drop_count_3", 32'(b_drop_count), 32'(exp_drop_3));
        // Two more illegal beats: a 2-bit counter stays saturated at 3.
        b_in_valid = 1'b1;
        b_in_sel   = 3'd7;
        tick();
        b_in_sel = 3'd5;
        tick();
        b_in_valid = 1'b0;
        check("drop_sat_no_valid", 32'(b_out_valid), 32'h0);
        check("drop_count_sat", 32'(b_drop_count), 32'(exp_drop_3));
        check("drop_a_zero", 32'(a_drop_count), 32'h0);

        // Asynchronous reset while full and stalled.
        a_out_ready = 4'h0;
        a_in_valid  = 1'b1;
        a_in_sel    = 2'd0;
        a_in_data   = 8'h99;
        tick();
        a_in_valid = 1'b0;
        check("pre_rst_valid", 32'(a_out_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(a_out_valid), 32'h0);
        check("async_rst_data", 32'(a_out_data), 32'h0);
        check("async_rst_in_ready", 32'(a_in_ready), 32'h0);
        check("async_rst_drop_b", 32'(b_drop_count), 32'h0);
        tick();
        tick();
        rst_n       = 1'b1;
        a_out_ready = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_stale_beat", 32'(a_out_valid), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
